// File: rtl/obstacle_pool.sv
// Pooled obstacle manager: spawn handshake with gap rule, per-frame fixed-point motion, retirement.
// Optional duplicate-type spawn filter enabled by defining OBSTACLE_POOL_DUP_FILTER_EN.
module obstacle_pool #(
    parameter int unsigned NUM_SLOTS  = 3,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned GAME_WIDTH = 600,
    parameter int unsigned MAX_DUP    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          update,
    input  logic                          start,
    input  logic                          crash,
    input  logic [14:0]                   speed,
    input  logic                          spawn_valid,
    output logic                          spawn_ready,
    input  logic [2:0]                    spawn_typ,
    input  logic [9:0]                    spawn_width,
    input  logic [10:0]                   spawn_gap,
    input  logic signed [11:0]            spawn_offset,
    output logic [NUM_SLOTS-1:0]          obs_active,
    output logic signed [NUM_SLOTS*11-1:0] obs_x,
    output logic [NUM_SLOTS*10-1:0]       obs_width,
    output logic [NUM_SLOTS*3-1:0]        obs_typ,
    output logic                          removed,
    output logic                          dup_rejected
);

    localparam int unsigned XW   = 21;
    localparam int unsigned PXW  = 11;
    localparam int unsigned WW   = 10;
    localparam int unsigned TW   = 3;
    localparam int unsigned GW   = 11;
    localparam int unsigned OW   = 12;
    localparam int unsigned SUMW = 14;
    localparam int unsigned IDXW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNTW = 4;

    localparam logic signed [XW-1:0]   SPAWN_X = XW'(GAME_WIDTH << FRAC_BITS);
    localparam logic signed [SUMW-1:0] GW_S    = SUMW'(GAME_WIDTH);

    // Elaboration-time parameter sanity checks
    if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
        $error("obstacle_pool: NUM_SLOTS must be 1..8");
    end
    if (MAX_DUP < 1 || MAX_DUP >= (1 << CNTW)) begin : g_bad_dup
        $error("obstacle_pool: MAX_DUP out of range");
    end

    typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} state_t;

    state_t                 state;
    logic signed [XW-1:0]   x_fp     [NUM_SLOTS];
    logic [WW-1:0]          width_q  [NUM_SLOTS];
    logic [TW-1:0]          typ_q    [NUM_SLOTS];
    logic [GW-1:0]          gap_q    [NUM_SLOTS];
    logic signed [OW-1:0]   offset_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   active_q;
    logic                   newest_valid;
    logic [IDXW-1:0]        newest_idx;
    logic                   removed_q;
    logic                   dup_rejected_q;

    logic signed [PXW-1:0]  px       [NUM_SLOTS];
    logic signed [SUMW-1:0] slot_end [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   retire;
    logic                   free_found;
    logic [IDXW-1:0]        free_idx;
    logic signed [SUMW-1:0] newest_end;
    logic                   gap_ok;
    logic                   dup_block;
    logic                   accept;

`ifdef OBSTACLE_POOL_DUP_FILTER_EN
    logic [TW-1:0]   last_typ;
    logic [CNTW-1:0] dup_cnt;
    assign dup_block = (spawn_typ == last_typ) && (dup_cnt == CNTW'(MAX_DUP));
`else
    assign dup_block = 1'b0;
`endif

    // Integer positions, retire detection and lowest free slot, all from pre-update state
    always_comb begin
        retire     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            px[i]       = PXW'(x_fp[i] >>> FRAC_BITS);
            slot_end[i] = SUMW'(px[i]) + $signed(SUMW'(width_q[i]));
            retire[i]   = active_q[i] && (slot_end[i] <= 0);
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        newest_end = slot_end[newest_idx] + $signed(SUMW'(gap_q[newest_idx]));
        gap_ok     = !newest_valid || (newest_end < GW_S);
    end

    assign spawn_ready = (state == RUNNING) && free_found && gap_ok && !dup_block;
    assign accept      = update && spawn_valid && spawn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            active_q       <= '0;
            newest_valid   <= 1'b0;
            newest_idx     <= '0;
            removed_q      <= 1'b0;
            dup_rejected_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_fp[i]     <= '0;
                width_q[i]  <= '0;
                typ_q[i]    <= '0;
                gap_q[i]    <= '0;
                offset_q[i] <= '0;
            end
`ifdef OBSTACLE_POOL_DUP_FILTER_EN
            last_typ <= '0;
            dup_cnt  <= '0;
`endif
        end else begin
            removed_q      <= 1'b0;
            dup_rejected_q <= 1'b0;
            if (update) begin
                dup_rejected_q <= spawn_valid && dup_block;
                case (state)
                    IDLE: begin
                        if (crash) begin
                            state <= CRASHED;
                        end else if (start) begin
                            state <= RUNNING;
                        end
                    end
                    RUNNING: begin
                        if (crash) begin
                            state <= CRASHED;
                        end
                        // Retiring slots stop moving; others advance by speed minus their offset
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (retire[i]) begin
                                active_q[i] <= 1'b0;
                            end else if (active_q[i]) begin
                                x_fp[i] <= x_fp[i] - $signed(XW'(speed)) + XW'(offset_q[i]);
                            end
                        end
                        removed_q <= |retire;
                        if (newest_valid && retire[newest_idx]) begin
                            newest_valid <= 1'b0;
                        end
                        // NONE completes the handshake without occupying a slot
                        if (accept && (spawn_typ != '0)) begin
                            active_q[free_idx] <= 1'b1;
                            x_fp[free_idx]     <= SPAWN_X;
                            width_q[free_idx]  <= spawn_width;
                            typ_q[free_idx]    <= spawn_typ;
                            gap_q[free_idx]    <= spawn_gap;
                            offset_q[free_idx] <= spawn_offset;
                            newest_idx         <= free_idx;
                            newest_valid       <= 1'b1;
                        end
`ifdef OBSTACLE_POOL_DUP_FILTER_EN
                        if (accept) begin
                            last_typ <= spawn_typ;
                            if ((spawn_typ == last_typ) && (dup_cnt != '0)) begin
                                if (dup_cnt < CNTW'(MAX_DUP)) begin
                                    dup_cnt <= dup_cnt + CNTW'(1);
                                end
                            end else begin
                                dup_cnt <= CNTW'(1);
                            end
                        end
`endif
                    end
                    CRASHED: begin
                        if (!crash && start) begin
                            state        <= IDLE;
                            active_q     <= '0;
                            newest_valid <= 1'b0;
                            newest_idx   <= '0;
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                x_fp[i]     <= '0;
                                width_q[i]  <= '0;
                                typ_q[i]    <= '0;
                                gap_q[i]    <= '0;
                                offset_q[i] <= '0;
                            end
`ifdef OBSTACLE_POOL_DUP_FILTER_EN
                            last_typ <= '0;
                            dup_cnt  <= '0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Flatten per-slot state onto the packed output buses
    always_comb begin
        obs_x     = '0;
        obs_width = '0;
        obs_typ   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            obs_x[i*PXW +: PXW]   = px[i];
            obs_width[i*WW +: WW] = width_q[i];
            obs_typ[i*TW +: TW]   = typ_q[i];
        end
    end

    assign obs_active   = active_q;
    assign removed      = removed_q;
    assign dup_rejected = dup_rejected_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Self-checking bench for obstacle_pool: directed scenarios plus randomized traffic
// compared against an integer reference model of the pool rules.
module tb_obstacle_pool;

    localparam int NS = 3;
    localparam int FB = 10;
    localparam int GWD = 600;
    localparam int MD = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               update;
    logic               start;
    logic               crash;
    logic [14:0]        speed;
    logic               spawn_valid;
    logic               spawn_ready;
    logic [2:0]         spawn_typ;
    logic [9:0]         spawn_width;
    logic [10:0]        spawn_gap;
    logic signed [11:0] spawn_offset;
    logic [NS-1:0]      obs_active;
    logic signed [NS*11-1:0] obs_x;
    logic [NS*10-1:0]   obs_width;
    logic [NS*3-1:0]    obs_typ;
    logic               removed;
    logic               dup_rejected;

    obstacle_pool #(.NUM_SLOTS(NS), .FRAC_BITS(FB), .GAME_WIDTH(GWD), .MAX_DUP(MD)) dut (
        .clk(clk), .rst(rst), .update(update), .start(start), .crash(crash), .speed(speed),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_typ(spawn_typ),
        .spawn_width(spawn_width), .spawn_gap(spawn_gap), .spawn_offset(spawn_offset),
        .obs_active(obs_active), .obs_x(obs_x), .obs_width(obs_width), .obs_typ(obs_typ),
        .removed(removed), .dup_rejected(dup_rejected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: 0 idle, 1 running, 2 crashed; positions in plain integer fixed point
    int m_state;
    int m_x[NS], m_w[NS], m_t[NS], m_g[NS], m_o[NS];
    bit m_a[NS];
    int m_newest;
    bit m_removed, m_dup;
    int m_last, m_cnt;
    bit dut_ready_seen;

    function automatic int px_of(input int xfp);
        return xfp >>> FB;
    endfunction

    function automatic int dut_px(input int i);
        logic signed [10:0] v;
        v = obs_x[i*11 +: 11];
        return int'(v);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_w[i] = 0; m_t[i] = 0; m_g[i] = 0; m_o[i] = 0; m_a[i] = 0;
        end
        m_newest = -1;
        m_last = 0;
        m_cnt = 0;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NS; i++) if (!m_a[i]) return i;
        return -1;
    endfunction

    function automatic bit dup_blocked(input int typ);
`ifdef OBSTACLE_POOL_DUP_FILTER_EN
        return (typ == m_last) && (m_cnt == MD);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready(input int typ);
        if (m_state != 1 || lowest_free() < 0) return 1'b0;
        if (m_newest >= 0 && px_of(m_x[m_newest]) + m_w[m_newest] + m_g[m_newest] >= GWD) return 1'b0;
        if (dup_blocked(typ)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_update(input bit st, input bit cr, input bit sv, input int typ,
                                         input int w, input int g, input int off, input int spd);
        bit acc;
        int fs;
        acc = sv && model_ready(typ);
        m_dup = sv && dup_blocked(typ);
        m_removed = 1'b0;
        case (m_state)
            0: if (cr) m_state = 2; else if (st) m_state = 1;
            1: begin
                fs = lowest_free();
                for (int i = 0; i < NS; i++) begin
                    if (m_a[i]) begin
                        if (px_of(m_x[i]) + m_w[i] <= 0) begin
                            m_a[i] = 1'b0;
                            m_removed = 1'b1;
                            if (m_newest == i) m_newest = -1;
                        end else begin
                            m_x[i] = m_x[i] - spd + m_o[i];
                        end
                    end
                end
                if (acc && typ != 0) begin
                    m_a[fs] = 1'b1; m_x[fs] = GWD * 1024; m_w[fs] = w; m_t[fs] = typ;
                    m_g[fs] = g; m_o[fs] = off; m_newest = fs;
                end
                if (acc) begin
                    if (typ == m_last && m_cnt > 0) begin
                        if (m_cnt < MD) m_cnt++;
                    end else begin
                        m_cnt = 1;
                    end
                    m_last = typ;
                end
                if (cr) m_state = 2;
            end
            default: if (!cr && st) begin model_clear(); m_state = 0; end
        endcase
    endfunction

    task automatic compare_all();
        check_eq("removed", int'(removed), int'(m_removed));
        check_eq("dup_rejected", int'(dup_rejected), int'(m_dup));
        for (int i = 0; i < NS; i++) begin
            check_eq($sformatf("active%0d", i), int'(obs_active[i]), int'(m_a[i]));
            if (m_a[i]) begin
                check_eq($sformatf("x%0d", i), dut_px(i), px_of(m_x[i]));
                check_eq($sformatf("width%0d", i), int'(obs_width[i*10 +: 10]), m_w[i]);
                check_eq($sformatf("typ%0d", i), int'(obs_typ[i*3 +: 3]), m_t[i]);
            end
        end
    endtask

    task automatic cycle(input bit upd, input bit st, input bit cr, input bit sv, input int typ,
                         input int w, input int g, input int off, input int spd);
        bit exp_ready;
        @(negedge clk);
        update = upd; start = st; crash = cr; spawn_valid = sv;
        spawn_typ = 3'(typ); spawn_width = 10'(w); spawn_gap = 11'(g);
        spawn_offset = 12'(off); speed = 15'(spd);
        #1;
        exp_ready = model_ready(typ);
        dut_ready_seen = spawn_ready;
        check_eq("spawn_ready", int'(spawn_ready), int'(exp_ready));
        if (upd) begin
            model_update(st, cr, sv, typ, w, g, off, spd);
        end else begin
            m_removed = 1'b0;
            m_dup = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; update = 1'b0; spawn_valid = 1'b0; start = 1'b0; crash = 1'b0;
        @(posedge clk);
        #1;
        m_state = 0; model_clear(); m_removed = 0; m_dup = 0;
        check_eq("rst_active", int'(obs_active), 0);
        check_eq("rst_ready", int'(spawn_ready), 0);
        check_eq("rst_removed", int'(removed), 0);
        check_eq("rst_dup", int'(dup_rejected), 0);
        for (int i = 0; i < NS; i++) begin
            check_eq($sformatf("rst_x%0d", i), dut_px(i), 0);
            check_eq($sformatf("rst_w%0d", i), int'(obs_width[i*10 +: 10]), 0);
            check_eq($sformatf("rst_t%0d", i), int'(obs_typ[i*3 +: 3]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int first_k;
        int tries;
        rst = 1'b1; update = 1'b0; start = 1'b0; crash = 1'b0; spawn_valid = 1'b0;
        spawn_typ = '0; spawn_width = '0; spawn_gap = '0; spawn_offset = '0; speed = '0;
        m_state = 0; model_clear();
        do_reset();

        // Start, then first spawn and its motion at 6 px per frame
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 6144);
        cycle(1, 0, 0, 1, 1, 17, 120, 0, 6144);
        check_eq("first_x", dut_px(0), 600);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 6144);
        check_eq("first_x_m1", dut_px(0), 594);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 6144);
        check_eq("first_x_m2", dut_px(0), 588);

        // Gap rule: second spawn offered until accepted
        k = 2;
        first_k = -1;
        while (k < 100) begin
            cycle(1, 0, 0, 1, 2, 30, 0, 0, 6144);
            if (dut_ready_seen) begin
                first_k = k;
                break;
            end
            k++;
        end
        check_eq("gap_wait", first_k, 23);

        // Crash freezes positions; start clears to idle, a second start runs again
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 6144);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 1, 20, 0, 0, 6144);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 6144);
        check_eq("clear_active", int'(obs_active), 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 6144);

        // Pterodactyl with positive offset: net 7885 per frame
        cycle(1, 0, 0, 1, 3, 40, 0, 819, 8704);
        check_eq("ptero_x0", dut_px(0), 600);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 8704);
        check_eq("ptero_x1", dut_px(0), 592);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 8704);
        check_eq("ptero_x2", dut_px(0), 584);

        // Fill pool with zero-gap obstacles and let them retire
        for (int i = 0; i < 200; i++) cycle(1, 0, 0, 1, 1, 10, 0, 0, 12000);

`ifdef OBSTACLE_POOL_DUP_FILTER_EN
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 12000);
        tries = 0;
        while (tries < 60) begin
            cycle(1, 0, 0, 1, 2, 10, 0, 0, 12000);
            tries++;
        end
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 1, 1, 10, 0, 0, 12000);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                      int'($urandom_range(0, 3)), int'($urandom_range(5, 200)),
                      int'($urandom_range(0, 150)), int'($urandom_range(0, 600)) - 300,
                      int'($urandom_range(2048, 12000)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
